// File: rtl/ahb_sram_phase_ctrl_if.sv
// ---------------------------------------------------------------------------
// ahb_sram_phase_ctrl_if
// AHB-Lite slave-side bus bundle for the SRAM phase controller.
//   master modport : drives address/control/write data, samples response
//   slave  modport : samples address/control/write data, drives response
// Signals: HSEL, HADDR[31:0], HTRANS[1:0], HWRITE, HSIZE[2:0], HREADY,
//          HWDATA[31:0] (master -> slave); HRDATA[31:0], HREADYOUT,
//          HRESP (slave -> master).
// ---------------------------------------------------------------------------
interface ahb_sram_phase_ctrl_if;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic        HREADY;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HREADYOUT;
   logic        HRESP;

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
      input  HRDATA, HREADYOUT, HRESP
   );

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
      output HRDATA, HREADYOUT, HRESP
   );
endinterface

// File: rtl/ahb_sram_phase_ctrl.sv
// ---------------------------------------------------------------------------
// ahb_sram_phase_ctrl
// AHB-Lite slave front end for a 2**ADDR_WIDTH x 32 synchronous SRAM.
// Registers the address phase, produces byte lanes, strobes the SRAM for a
// single cycle, inserts one wait state on reads and answers misaligned
// transfers with a two-cycle ERROR response.
// Ports:
//   HCLK, HRESETn : clock, asynchronous active-low reset
//   bus           : AHB-Lite slave modport (request in, response out)
//   mem_cs/mem_wr/mem_rd : SRAM chip select, write and read strobes
//   mem_ad        : SRAM word address (registered address phase)
//   mem_di        : SRAM write data (HWDATA during the write data phase)
//   mem_be        : SRAM byte enables, bit i covers data[8i+7:8i]
//   mem_do        : SRAM read data, valid the cycle after mem_rd
// ---------------------------------------------------------------------------
module ahb_sram_phase_ctrl #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   ahb_sram_phase_ctrl_if.slave  bus,
   output logic                  mem_cs,
   output logic [ADDR_WIDTH-1:0] mem_ad,
   output logic [DATA_WIDTH-1:0] mem_di,
   output logic                  mem_wr,
   output logic                  mem_rd,
   output logic [3:0]            mem_be,
   input  logic [DATA_WIDTH-1:0] mem_do
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WRITE     = 3'd1,
      ST_READ_WAIT = 3'd2,
      ST_READ_DONE = 3'd3,
      ST_ERR1      = 3'd4,
      ST_ERR2      = 3'd5
   } state_t;

   state_t                state_r;
   state_t                next_state_s;
   logic [ADDR_WIDTH-1:0] addr_r;
   logic [3:0]            lanes_r;
   logic                  ready_s;
   logic                  accept_s;
   logic                  misaligned_s;
   logic                  unused_s;

   // Byte lanes for a transfer of the given size at the given byte offset.
   function automatic logic [3:0] lanes_f(input logic [2:0] size, input logic [1:0] offset);
      logic [3:0] lanes;
      case (size)
         3'd0:    lanes = 4'b0001 << offset;
         3'd1:    lanes = offset[1] ? 4'b1100 : 4'b0011;
         3'd2:    lanes = 4'b1111;
         default: lanes = 4'b0000;
      endcase
      return lanes;
   endfunction

   // True when size/offset do not form a naturally aligned legal transfer.
   function automatic logic misaligned_f(input logic [2:0] size, input logic [1:0] offset);
      logic bad;
      case (size)
         3'd0:    bad = 1'b0;
         3'd1:    bad = offset[0];
         3'd2:    bad = (offset != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   // Address bits above the SRAM range are dropped (address wraps), and
   // HTRANS[0] only distinguishes NONSEQ/SEQ, which this slave treats alike.
   assign unused_s = ^{bus.HADDR[31:ADDR_WIDTH+2], bus.HTRANS[0]};

   // Request qualification: a transfer is only taken in a ready state.
   always_comb begin
      accept_s     = bus.HSEL & bus.HREADY & bus.HTRANS[1];
      misaligned_s = misaligned_f(bus.HSIZE, bus.HADDR[1:0]);
      case (state_r)
         ST_IDLE, ST_WRITE, ST_READ_DONE, ST_ERR2: ready_s = 1'b1;
         default:                                  ready_s = 1'b0;
      endcase
   end

   // State register.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Address-phase capture: word address and byte lanes of the accepted transfer.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         addr_r  <= '0;
         lanes_r <= 4'b0000;
      end else if (ready_s && accept_s) begin
         addr_r  <= bus.HADDR[ADDR_WIDTH+1:2];
         lanes_r <= lanes_f(bus.HSIZE, bus.HADDR[1:0]);
      end else begin
         addr_r  <= addr_r;
         lanes_r <= lanes_r;
      end
   end

   // Next-state decode.
   always_comb begin
      next_state_s = ST_IDLE;
      case (state_r)
         ST_IDLE, ST_WRITE, ST_READ_DONE, ST_ERR2: begin
            if (!accept_s) begin
               next_state_s = ST_IDLE;
            end else if (misaligned_s) begin
               next_state_s = ST_ERR1;
            end else if (bus.HWRITE) begin
               next_state_s = ST_WRITE;
            end else begin
               next_state_s = ST_READ_WAIT;
            end
         end
         ST_READ_WAIT: next_state_s = ST_READ_DONE;
         ST_ERR1:      next_state_s = ST_ERR2;
         default:      next_state_s = ST_IDLE;
      endcase
   end

   // Output decode from the state register; reset forces IDLE outputs at once.
   always_comb begin
      bus.HREADYOUT = 1'b1;
      bus.HRESP     = 1'b0;
      bus.HRDATA    = 32'h0000_0000;
      mem_cs        = 1'b0;
      mem_wr        = 1'b0;
      mem_rd        = 1'b0;
      mem_be        = 4'b0000;
      mem_di        = '0;
      mem_ad        = addr_r;
      case (state_r)
         ST_IDLE: begin
            bus.HREADYOUT = 1'b1;
         end
         ST_WRITE: begin
            mem_cs = 1'b1;
            mem_wr = 1'b1;
            mem_di = bus.HWDATA;
            mem_be = lanes_r;
         end
         ST_READ_WAIT: begin
            mem_cs        = 1'b1;
            mem_rd        = 1'b1;
            mem_be        = lanes_r;
            bus.HREADYOUT = 1'b0;
         end
         ST_READ_DONE: begin
            bus.HRDATA = mem_do;
         end
         ST_ERR1: begin
            bus.HRESP     = 1'b1;
            bus.HREADYOUT = 1'b0;
         end
         ST_ERR2: begin
            bus.HRESP = 1'b1;
         end
         default: begin
            bus.HREADYOUT = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_ahb_sram_phase_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ahb_sram_phase_ctrl
// Directed bench for ahb_sram_phase_ctrl with a behavioural 256x32 SRAM.
// ---------------------------------------------------------------------------
module tb_ahb_sram_phase_ctrl;
   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        mem_cs, mem_wr, mem_rd;
   logic [7:0]  mem_ad;
   logic [31:0] mem_di;
   logic [3:0]  mem_be;
   logic [31:0] mem_do = 32'h0;
   logic        hready_low;
   int          checks = 0;
   int          failures = 0;
   logic [31:0] sram [0:255];

   ahb_sram_phase_ctrl_if bus();

   // Single slave on the bus: HREADY follows HREADYOUT unless forced low.
   assign bus.HREADY = bus.HREADYOUT & ~hready_low;

   ahb_sram_phase_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus.slave),
      .mem_cs(mem_cs), .mem_ad(mem_ad), .mem_di(mem_di), .mem_wr(mem_wr),
      .mem_rd(mem_rd), .mem_be(mem_be), .mem_do(mem_do)
   );

   always #5 HCLK = ~HCLK;

   // Behavioural synchronous SRAM with byte enables.
   always @(posedge HCLK) begin
      if (mem_cs && mem_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (mem_be[i]) sram[mem_ad][8*i +: 8] <= mem_di[8*i +: 8];
         end
      end
      if (mem_cs && mem_rd) mem_do <= sram[mem_ad];
   end

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic drive_idle();
      bus.HSEL   = 1'b0;
      bus.HTRANS = 2'b00;
      bus.HWRITE = 1'b0;
      bus.HSIZE  = 3'd0;
      bus.HADDR  = 32'h0;
      hready_low = 1'b0;
   endtask

   task automatic addr_phase(input logic wr, input logic [31:0] a, input logic [2:0] sz);
      bus.HSEL   = 1'b1;
      bus.HTRANS = 2'b10;
      bus.HWRITE = wr;
      bus.HSIZE  = sz;
      bus.HADDR  = a;
      hready_low = 1'b0;
   endtask

   task automatic test_reset();
      HRESETn = 1'b0;
      drive_idle();
      bus.HWDATA = 32'h0;
      #12;
      checks++;
      if ({bus.HREADYOUT, bus.HRESP} !== 2'b10) begin
         failures++; $display("FAIL reset_resp: got %b want 10", {bus.HREADYOUT, bus.HRESP});
      end
      checks++;
      if (bus.HRDATA !== 32'h0) begin
         failures++; $display("FAIL reset_hrdata: got %h want 0", bus.HRDATA);
      end
      checks++;
      if ({mem_cs, mem_wr, mem_rd, mem_be, mem_ad, mem_di} !== 47'h0) begin
         failures++; $display("FAIL reset_mem: got cs%b wr%b rd%b be%b ad%h di%h want all 0",
                              mem_cs, mem_wr, mem_rd, mem_be, mem_ad, mem_di);
      end
      HRESETn = 1'b1;
      step();
      checks++;
      if ({bus.HREADYOUT, bus.HRESP, mem_cs, mem_wr, mem_rd} !== 5'b10000) begin
         failures++; $display("FAIL reset_release: got %b want 10000",
                              {bus.HREADYOUT, bus.HRESP, mem_cs, mem_wr, mem_rd});
      end
   endtask

   task automatic test_word_write_read();
      addr_phase(1'b1, 32'h0000_0010, 3'd2);
      step();
      bus.HWDATA = 32'hDEAD_BEEF;
      drive_idle();
      #1;
      checks++;
      if ({mem_cs, mem_wr, mem_rd, bus.HREADYOUT} !== 4'b1101 || mem_ad !== 8'd4 ||
          mem_be !== 4'b1111 || mem_di !== 32'hDEAD_BEEF) begin
         failures++; $display("FAIL word_write: cs/wr/rd/rdy=%b ad=%h be=%b di=%h want 1101 04 1111 deadbeef",
                              {mem_cs, mem_wr, mem_rd, bus.HREADYOUT}, mem_ad, mem_be, mem_di);
      end
      step();
      checks++;
      if ({mem_cs, mem_wr, mem_rd} !== 3'b000) begin
         failures++; $display("FAIL word_write_one_cycle: got %b want 000", {mem_cs, mem_wr, mem_rd});
      end
      addr_phase(1'b0, 32'h0000_0010, 3'd2);
      step();
      drive_idle();
      #1;
      checks++;
      if ({mem_cs, mem_wr, mem_rd, bus.HREADYOUT} !== 4'b1010 || mem_ad !== 8'd4 ||
          bus.HRDATA !== 32'h0) begin
         failures++; $display("FAIL read_wait: cs/wr/rd/rdy=%b ad=%h hrdata=%h want 1010 04 0",
                              {mem_cs, mem_wr, mem_rd, bus.HREADYOUT}, mem_ad, bus.HRDATA);
      end
      step();
      checks++;
      if (bus.HREADYOUT !== 1'b1 || bus.HRDATA !== 32'hDEAD_BEEF || {mem_cs, mem_rd} !== 2'b00) begin
         failures++; $display("FAIL read_done: rdy=%b hrdata=%h cs/rd=%b want 1 deadbeef 00",
                              bus.HREADYOUT, bus.HRDATA, {mem_cs, mem_rd});
      end
      step();
      checks++;
      if (bus.HRDATA !== 32'h0) begin
         failures++; $display("FAIL hrdata_after_read: got %h want 0", bus.HRDATA);
      end
   endtask

   task automatic test_lanes();
      addr_phase(1'b1, 32'h0000_0013, 3'd0);
      step();
      bus.HWDATA = 32'hAA00_0000;
      drive_idle();
      #1;
      checks++;
      if (mem_be !== 4'b1000 || mem_wr !== 1'b1 || mem_ad !== 8'd4) begin
         failures++; $display("FAIL byte_write_be: be=%b wr=%b ad=%h want 1000 1 04", mem_be, mem_wr, mem_ad);
      end
      step();
      addr_phase(1'b1, 32'h0000_0012, 3'd1);
      step();
      bus.HWDATA = 32'h1234_0000;
      drive_idle();
      #1;
      checks++;
      if (mem_be !== 4'b1100 || mem_wr !== 1'b1) begin
         failures++; $display("FAIL half_write_be: be=%b wr=%b want 1100 1", mem_be, mem_wr);
      end
      step();
      addr_phase(1'b0, 32'h0000_0011, 3'd0);
      step();
      drive_idle();
      #1;
      checks++;
      if (mem_be !== 4'b0010 || mem_rd !== 1'b1) begin
         failures++; $display("FAIL byte_read_be: be=%b rd=%b want 0010 1", mem_be, mem_rd);
      end
      step();
      checks++;
      if (bus.HRDATA !== 32'h1234_BEEF) begin
         failures++; $display("FAIL merged_readback: got %h want 1234beef", bus.HRDATA);
      end
      step();
   endtask

   task automatic test_misaligned();
      logic [31:0] addrs [2];
      logic [2:0]  sizes [2];
      addrs[0] = 32'h0000_0002; sizes[0] = 3'd2;
      addrs[1] = 32'h0000_0000; sizes[1] = 3'd3;
      for (int i = 0; i < 2; i++) begin
         addr_phase(1'b1, addrs[i], sizes[i]);
         step();
         drive_idle();
         #1;
         checks++;
         if ({bus.HRESP, bus.HREADYOUT, mem_cs, mem_wr, mem_rd} !== 5'b10000) begin
            failures++; $display("FAIL err1_%0d: resp/rdy/cs/wr/rd=%b want 10000", i,
                                 {bus.HRESP, bus.HREADYOUT, mem_cs, mem_wr, mem_rd});
         end
         step();
         checks++;
         if ({bus.HRESP, bus.HREADYOUT, mem_cs, mem_wr, mem_rd} !== 5'b11000) begin
            failures++; $display("FAIL err2_%0d: resp/rdy/cs/wr/rd=%b want 11000", i,
                                 {bus.HRESP, bus.HREADYOUT, mem_cs, mem_wr, mem_rd});
         end
         step();
         checks++;
         if ({bus.HRESP, bus.HREADYOUT, mem_cs} !== 3'b010) begin
            failures++; $display("FAIL err_end_%0d: resp/rdy/cs=%b want 010", i,
                                 {bus.HRESP, bus.HREADYOUT, mem_cs});
         end
      end
   endtask

   task automatic test_back_to_back();
      addr_phase(1'b1, 32'h0000_0004, 3'd2);
      step();
      bus.HWDATA = 32'hCAFE_F00D;
      addr_phase(1'b0, 32'h0000_0004, 3'd2);
      #1;
      checks++;
      if ({mem_cs, mem_wr, mem_rd, bus.HREADYOUT} !== 4'b1101 || mem_ad !== 8'd1 ||
          mem_di !== 32'hCAFE_F00D) begin
         failures++; $display("FAIL b2b_write1: cs/wr/rd/rdy=%b ad=%h di=%h want 1101 01 cafef00d",
                              {mem_cs, mem_wr, mem_rd, bus.HREADYOUT}, mem_ad, mem_di);
      end
      step();
      addr_phase(1'b1, 32'h0000_0008, 3'd2);
      #1;
      checks++;
      if ({mem_cs, mem_wr, mem_rd, bus.HREADYOUT} !== 4'b1010 || mem_ad !== 8'd1) begin
         failures++; $display("FAIL b2b_read_wait: cs/wr/rd/rdy=%b ad=%h want 1010 01",
                              {mem_cs, mem_wr, mem_rd, bus.HREADYOUT}, mem_ad);
      end
      step();
      checks++;
      if ({mem_cs, bus.HREADYOUT} !== 2'b01 || bus.HRDATA !== 32'hCAFE_F00D) begin
         failures++; $display("FAIL b2b_read_done: cs/rdy=%b hrdata=%h want 01 cafef00d",
                              {mem_cs, bus.HREADYOUT}, bus.HRDATA);
      end
      step();
      bus.HWDATA = 32'h0BAD_CAFE;
      drive_idle();
      #1;
      checks++;
      if ({mem_cs, mem_wr, mem_rd, bus.HREADYOUT} !== 4'b1101 || mem_ad !== 8'd2 ||
          mem_di !== 32'h0BAD_CAFE) begin
         failures++; $display("FAIL b2b_write2: cs/wr/rd/rdy=%b ad=%h di=%h want 1101 02 0badcafe",
                              {mem_cs, mem_wr, mem_rd, bus.HREADYOUT}, mem_ad, mem_di);
      end
      step();
   endtask

   task automatic test_wrap();
      addr_phase(1'b1, 32'h0000_0400, 3'd2);
      step();
      bus.HWDATA = 32'h1111_2222;
      addr_phase(1'b1, 32'h0000_07FC, 3'd2);
      #1;
      checks++;
      if (mem_ad !== 8'h00 || mem_wr !== 1'b1) begin
         failures++; $display("FAIL wrap_400: ad=%h wr=%b want 00 1", mem_ad, mem_wr);
      end
      step();
      bus.HWDATA = 32'h3333_4444;
      drive_idle();
      #1;
      checks++;
      if (mem_ad !== 8'hFF || mem_wr !== 1'b1) begin
         failures++; $display("FAIL wrap_7fc: ad=%h wr=%b want ff 1", mem_ad, mem_wr);
      end
      step();
   endtask

   task automatic test_gating();
      for (int i = 0; i < 3; i++) begin
         addr_phase(1'b1, 32'h0000_0020, 3'd2);
         if (i == 0) bus.HTRANS = 2'b01;
         if (i == 1) bus.HSEL = 1'b0;
         if (i == 2) hready_low = 1'b1;
         step();
         checks++;
         if ({mem_cs, mem_wr, mem_rd, bus.HRESP} !== 4'b0000 || mem_ad !== 8'hFF) begin
            failures++; $display("FAIL gating_%0d: cs/wr/rd/resp=%b ad=%h want 0000 ff", i,
                                 {mem_cs, mem_wr, mem_rd, bus.HRESP}, mem_ad);
         end
         step();
         checks++;
         if ({mem_cs, mem_wr, mem_rd} !== 3'b000) begin
            failures++; $display("FAIL gating_late_%0d: cs/wr/rd=%b want 000", i, {mem_cs, mem_wr, mem_rd});
         end
         drive_idle();
      end
      hready_low = 1'b0;
   endtask

   task automatic test_reset_mid();
      addr_phase(1'b0, 32'h0000_0010, 3'd2);
      step();
      drive_idle();
      #1;
      checks++;
      if (mem_rd !== 1'b1) begin
         failures++; $display("FAIL mid_pre_rd: got %b want 1", mem_rd);
      end
      HRESETn = 1'b0;
      #1;
      checks++;
      if ({mem_cs, mem_rd, bus.HREADYOUT, bus.HRESP} !== 4'b0010 || mem_ad !== 8'h00) begin
         failures++; $display("FAIL mid_reset_async: cs/rd/rdy/resp=%b ad=%h want 0010 00",
                              {mem_cs, mem_rd, bus.HREADYOUT, bus.HRESP}, mem_ad);
      end
      #2;
      HRESETn = 1'b1;
      addr_phase(1'b1, 32'h0000_000C, 3'd2);
      step();
      bus.HWDATA = 32'h5555_AAAA;
      drive_idle();
      #1;
      checks++;
      if ({mem_cs, mem_wr, mem_rd} !== 3'b110 || mem_ad !== 8'd3 || bus.HRDATA !== 32'h0) begin
         failures++; $display("FAIL post_reset_accept: cs/wr/rd=%b ad=%h hrdata=%h want 110 03 0",
                              {mem_cs, mem_wr, mem_rd}, mem_ad, bus.HRDATA);
      end
      step();
   endtask

   initial begin
      hready_low = 1'b0;
      test_reset();
      test_word_write_read();
      test_lanes();
      test_misaligned();
      test_back_to_back();
      test_wrap();
      test_gating();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ahb_sram_phase_ctrl.md
# ahb_sram_phase_ctrl

AHB-Lite slave front end that converts bus address/data phases into single-cycle strobes for the 256x32 synchronous SRAM macro. Sits between the AHB-Lite interconnect (decoder and read-data mux) and the SRAM. It registers the address phase, generates byte lanes, and inserts one wait state on reads. It also returns a two-cycle ERROR response for misaligned transfers.

## Interface
Parameters:
- ADDR_WIDTH, 8, word-address bits driven to the SRAM (depth 2**ADDR_WIDTH words)
- DATA_WIDTH, 32, data width; fixed at 32 in this design

Ports:
- HCLK  in  1  clock; one clock, all state on rising edge
- HRESETn  in  1  reset, asynchronous, active-low
- HSEL  in  1  slave select from decoder
- HADDR  in  32  byte address; bits [ADDR_WIDTH+1:2] used
- HTRANS  in  2  transfer type; transfer valid when HTRANS[1]=1 (NONSEQ/SEQ)
- HWRITE  in  1  1=write, 0=read
- HSIZE  in  3  0=byte, 1=halfword, 2=word, >2 illegal
- HREADY  in  1  bus ready (previous data phase complete)
- HWDATA  in  32  write data, valid in data phase
- HRDATA  out  32  read data to bus mux
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0=OKAY, 1=ERROR
- mem_cs  out  1  SRAM chip select
- mem_ad  out  ADDR_WIDTH  SRAM word address
- mem_di  out  32  SRAM write data
- mem_wr  out  1  SRAM write strobe
- mem_rd  out  1  SRAM read strobe
- mem_be  out  4  byte enables, bit i = HWDATA[8i+7:8i]
- mem_do  in  32  SRAM read data, valid the cycle after mem_rd is sampled

## Operation
- Accept: HSEL & HREADY & HTRANS[1] at a rising edge. On accept, register addr, HWRITE, HSIZE, and byte lanes. Upper address bits are ignored, so the address wraps modulo the SRAM size.
- Byte lanes:
  - HSIZE 0: one-hot at HADDR[1:0].
  - HSIZE 1: 0011 if HADDR[1]=0, else 1100.
  - HSIZE 2: 1111.
- Misaligned: any of the following is an error.
  - HSIZE 1 with HADDR[0]=1.
  - HSIZE 2 with HADDR[1:0]≠0.
  - HSIZE >2.
  - An error transfer never drives mem_cs, mem_wr or mem_rd.
- States: IDLE, WRITE, READ_WAIT, READ_DONE, ERR1, ERR2.
- From any state where HREADYOUT=1 (IDLE, WRITE, READ_DONE, ERR2):
  - accepted misaligned → ERR1
  - accepted write → WRITE
  - accepted read → READ_WAIT
  - otherwise → IDLE
- READ_WAIT → READ_DONE unconditionally.
- ERR1 → ERR2 unconditionally.
- In READ_WAIT and ERR1, HREADY is low on the bus, so no transfer is accepted.
- Outputs per state:
  - IDLE: HREADYOUT=1, HRESP=0, strobes low.
  - WRITE: mem_cs=mem_wr=1, mem_di=HWDATA, mem_be=registered lanes, HREADYOUT=1.
  - READ_WAIT: mem_cs=mem_rd=1, mem_be=registered lanes, HREADYOUT=0.
  - READ_DONE: HRDATA=mem_do, HREADYOUT=1.
  - ERR1: HRESP=1, HREADYOUT=0.
  - ERR2: HRESP=1, HREADYOUT=1.
- mem_ad is the registered word address in every state.
- HRDATA is 0 in every state except READ_DONE.
- Reset values: state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, mem_cs=mem_wr=mem_rd=0, mem_be=0, mem_ad=0, mem_di=0.

## Timing
- Write: address phase cycle N. Cycle N+1: mem_wr=1, HREADYOUT=1. Zero wait states.
- Read: address phase cycle N.
  - N+1: mem_rd=1, HREADYOUT=0.
  - N+2: HRDATA valid, HREADYOUT=1.
  - One wait state.
- Back-to-back: the next address phase overlaps the WRITE, READ_DONE or ERR2 cycle and is accepted there.
- Write then read to the same address: the write strobes in N+1 and the read strobes in N+2, so new data is returned. No hazard stall.
- Error: ERR1 and ERR2 are exactly two cycles; HRESP=1 in both.
- HSEL low or HTRANS IDLE/BUSY while in a ready state: go to IDLE, no strobe.
- Reset asserted mid-transfer (any state): all outputs take reset values immediately, without waiting for a clock edge. The pending transfer is dropped.
- After HRESETn deassertion: the first edge may accept a transfer.

## Test plan
- Reset:
  - Hold HRESETn=0, then release. Require HREADYOUT=1, HRESP=0, HRDATA=0, all mem strobes 0.
  - Assert HRESETn=0 during READ_WAIT. Require mem_rd to drop in the same cycle and state to be IDLE.
- Word write then read:
  - Write 0xDEADBEEF to 0x0000_0010. Require mem_ad=4, mem_be=1111, mem_wr=1 for one cycle.
  - Read back from 0x0000_0010. Require HREADYOUT=0 for 1 cycle, then HRDATA=0xDEADBEEF.
- Byte and halfword lanes:
  - Byte write to 0x13. Require mem_be=1000.
  - Halfword write to 0x12. Require mem_be=1100.
  - Byte read from 0x11. Require mem_be=0010.
- Misaligned:
  - Word write to 0x02. Require HRESP=1 with HREADYOUT=0,1 over two cycles, and no mem_cs.
  - Repeat with HSIZE=3.
- Pipelining and wrap:
  - Back-to-back write 0x04, read 0x04, write 0x08 with no idle cycles. Require correct strobes each cycle, 0 wait states on writes, 1 on the read.
  - Write 0x0000_0400. Require mem_ad=0.
- Gating:
  - HTRANS=BUSY, or HSEL=0, or HREADY=0 with HTRANS=NONSEQ. Require no strobes and state unchanged/IDLE.
